// File: rtl/dtc_therm_vote_acc.sv
// Majority-vote accumulator for thermometer class codes: histogram over WIN samples, then emit argmax.
// Optional DTC_VOTE_FLUSH_EN adds a flush input that closes a partial window early.
module dtc_therm_vote_acc #(
    parameter int W     = 7,
    parameter int WIN   = 8,
    parameter int CNT_W = $clog2(WIN + 1),
    parameter int CLS_W = $clog2(W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_code,
`ifdef DTC_VOTE_FLUSH_EN
    input  logic             flush,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CLS_W-1:0] out_class,
    output logic [CNT_W-1:0] out_count,
    output logic             out_err,
    output logic             out_tie
);

    typedef enum logic [1:0] {S_ACC, S_VOTE, S_EMIT} state_e;

    state_e                 state_q, state_d;
    logic [W:0][CNT_W-1:0]  bin_q, bin_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic [CLS_W-1:0]       cls_q, cls_d;
    logic [CNT_W-1:0]       vcnt_q, vcnt_d;
    logic                   verr_q, verr_d;
    logic                   tie_q, tie_d;

    logic                   xfer, win_full, flush_go, code_ok;
    logic [CLS_W-1:0]       code_cls;
    logic [CNT_W-1:0]       cnt_inc;
    logic [CLS_W-1:0]       best_cls;
    logic [CNT_W-1:0]       best_cnt;
    logic                   best_tie;

    // Well-formed iff adding one carries through every set bit (ones contiguous from LSB).
    always_comb begin
        code_ok  = (in_code & (in_code + W'(1))) == '0;
        code_cls = '0;
        for (int i = 0; i < W; i++)
            code_cls = code_cls + CLS_W'(in_code[i]);
    end

    assign xfer     = in_valid & in_ready;
    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign win_full = xfer && (cnt_inc == CNT_W'(WIN));
`ifdef DTC_VOTE_FLUSH_EN
    assign flush_go = flush && (xfer || (cnt_q != '0));
`else
    assign flush_go = 1'b0;
`endif

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_ACC;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_ACC:   if (win_full || flush_go) state_d = S_VOTE;
            S_VOTE:  state_d = S_EMIT;
            S_EMIT:  if (out_ready) state_d = S_ACC;
            default: state_d = S_ACC;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready  = (state_q == S_ACC);
        out_valid = (state_q == S_EMIT);
    end

    // Histogram, sample counter and sticky error; cleared once the result is taken.
    always_comb begin
        bin_d = bin_q;
        cnt_d = cnt_q;
        err_d = err_q;
        if (state_q == S_EMIT && out_ready) begin
            bin_d = '0;
            cnt_d = '0;
            err_d = 1'b0;
        end else if (xfer) begin
            cnt_d = cnt_inc;
            if (code_ok) bin_d[code_cls] = bin_q[code_cls] + CNT_W'(1);
            else         err_d = 1'b1;
        end
    end

    // Strict '>' keeps the lowest index on ties; an empty histogram never flags a tie.
    always_comb begin
        best_cls = '0;
        best_cnt = '0;
        best_tie = 1'b0;
        for (int c = 0; c <= W; c++) begin
            if (bin_q[c] > best_cnt) begin
                best_cnt = bin_q[c];
                best_cls = CLS_W'(c);
                best_tie = 1'b0;
            end else if (bin_q[c] == best_cnt && best_cnt != '0) begin
                best_tie = 1'b1;
            end
        end
    end

    always_comb begin
        cls_d  = cls_q;
        vcnt_d = vcnt_q;
        verr_d = verr_q;
        tie_d  = tie_q;
        if (state_q == S_VOTE) begin
            cls_d  = best_cls;
            vcnt_d = best_cnt;
            verr_d = err_q;
            tie_d  = best_tie;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
            cls_q  <= '0;
            vcnt_q <= '0;
            verr_q <= 1'b0;
            tie_q  <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
            cls_q  <= cls_d;
            vcnt_q <= vcnt_d;
            verr_q <= verr_d;
            tie_q  <= tie_d;
        end
    end

    assign out_class = cls_q;
    assign out_count = vcnt_q;
    assign out_err   = verr_q;
    assign out_tie   = tie_q;

endmodule

// File: tb/tb_dtc_therm_vote_acc.sv
// Randomized bench for dtc_therm_vote_acc against a histogram/majority reference model.
module tb_dtc_therm_vote_acc;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [6:0] in_code = '0;
`ifdef DTC_VOTE_FLUSH_EN
    logic       flush = 1'b0;
`endif
    logic       in_ready, out_valid, out_err, out_tie;
    logic [2:0] out_class;
    logic [3:0] out_count;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    dtc_therm_vote_acc dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
`ifdef DTC_VOTE_FLUSH_EN
        .flush(flush),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
        .out_count(out_count), .out_err(out_err), .out_tie(out_tie)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: a code is legal iff it equals the all-ones mask of its own popcount.
    function automatic void model(input logic [6:0] q[$], output int cls, output int cnt,
                                  output int err, output int tie);
        int h[8];
        int k, nmax;
        logic [6:0] full, mask;
        full = 7'h7f;
        foreach (h[i]) h[i] = 0;
        err = 0;
        foreach (q[i]) begin
            k = $countones(q[i]);
            mask = full >> (7 - k);
            if (q[i] == mask) h[k]++;
            else err = 1;
        end
        cnt = 0;
        foreach (h[i]) if (h[i] > cnt) cnt = h[i];
        cls = 0;
        for (int i = 7; i >= 0; i--) if (h[i] == cnt) cls = i;
        nmax = 0;
        foreach (h[i]) if (h[i] == cnt) nmax++;
        tie = (cnt > 0 && nmax >= 2) ? 1 : 0;
        if (cnt == 0) cls = 0;
    endfunction

    // Called at a negedge; returns at the negedge just after the accepting posedge.
    task automatic send_code(input logic [6:0] c);
        int n = 0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        in_valid = 1'b1;
        in_code  = c;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_timeout", 32'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic get_result(input logic [6:0] q[$], input int stall);
        int cls, cnt, err, tie;
        int n = 0;
        model(q, cls, cnt, err, tie);
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("res_valid", 32'(out_valid), 1);
        chk("class", 32'(out_class), cls);
        chk("count", 32'(out_count), cnt);
        chk("err", 32'(out_err), err);
        chk("tie", 32'(out_tie), tie);
        chk("busy_ready", 32'(in_ready), 0);
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            in_code  = 7'($urandom);
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_class", 32'(out_class), cls);
            chk("hold_count", 32'(out_count), cnt);
            chk("hold_err", 32'(out_err), err);
            chk("hold_ready", 32'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("drop_valid", 32'(out_valid), 0);
        chk("ready_back", 32'(in_ready), 1);
        chk("keep_class", 32'(out_class), cls);
        chk("keep_count", 32'(out_count), cnt);
    endtask

    task automatic send_all(input logic [6:0] q[$]);
        foreach (q[i]) send_code(q[i]);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 0);
        chk({tag, "_ready"}, 32'(in_ready), 1);
        chk({tag, "_class"}, 32'(out_class), 0);
        chk({tag, "_count"}, 32'(out_count), 0);
        chk({tag, "_err"}, 32'(out_err), 0);
        chk({tag, "_tie"}, 32'(out_tie), 0);
    endtask

    initial begin
        logic [6:0] q[$];
        logic [6:0] c;
        int r;

        #1 chk_reset_vals("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: uniform window, latency from last accept
        q = {};
        repeat (8) q.push_back(7'b0001111);
        send_all(q);
        chk("lat_vote", 32'(out_valid), 0);
        @(negedge clk);
        chk("lat_emit", 32'(out_valid), 1);
        get_result(q, 0);

        // 2: tie resolves to lower class
        q = {};
        repeat (4) q.push_back(7'b0111111);
        repeat (4) q.push_back(7'b0000111);
        send_all(q);
        get_result(q, 1);

        // 3 + 4: malformed code, long stall, then a clean window
        q = {};
        repeat (7) q.push_back(7'b0000001);
        q.push_back(7'b0101111);
        send_all(q);
        get_result(q, 5);
        q = {};
        repeat (8) q.push_back(7'b0000011);
        send_all(q);
        get_result(q, 0);

        // async reset while a result is pending
        q = {};
        repeat (4) q.push_back(7'b0011111);
        repeat (3) q.push_back(7'b0000011);
        q.push_back(7'b1000000);
        send_all(q);
        @(negedge clk);
        chk("pre_rst_valid", 32'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("emit_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 5: async reset mid-window discards partial samples
        q = {};
        repeat (3) q.push_back(7'b0011111);
        send_all(q);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("win_rst");
        @(negedge clk);
        rst_n = 1'b1;
        q = {};
        repeat (7) q.push_back(7'b0000011);
        send_all(q);
        repeat (4) begin
            @(negedge clk);
            chk("no_early", 32'(out_valid), 0);
        end
        q.push_back(7'b0000011);
        send_code(7'b0000011);
        get_result(q, 0);

`ifdef DTC_VOTE_FLUSH_EN
        // 6: flush partial window, then flush on an empty window
        q = {};
        repeat (3) q.push_back(7'b0000111);
        send_all(q);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        get_result(q, 0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("empty_flush", 32'(out_valid), 0);
        end
`endif

        // random windows
        for (int w = 0; w < 25; w++) begin
            q = {};
            for (int s = 0; s < 8; s++) begin
                r = $urandom_range(0, 9);
                if (r < 4)      c = 7'h7f >> (7 - $urandom_range(0, 7));
                else if (r < 8) c = 7'h7f >> (7 - $urandom_range(2, 4));
                else            c = 7'($urandom);
                q.push_back(c);
            end
            send_all(q);
            get_result(q, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
